// File: rtl/fetch_pc_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_pc_sequencer
//
// Instruction-fetch stage. Owns the program counter and closes the next-PC
// loop through an external 2:1 mux: PC + PC_INCREMENT leaves on
// CC_FETCH_pcPlus4_OutBUS (mux data0) and the mux output comes back on
// CC_FETCH_nextPC_InBUS. The mux select (branch taken) is also
// CC_FETCH_redirect_In, which flushes the stage and refetches from nextPC.
//
// Fetches use a req/ack handshake to instruction memory. The returned word is
// held in a one-entry buffer and presented downstream with valid/ready.
//
// Ports
//   CLOCK_50                 in   single clock, rising edge
//   RESET_InHigh             in   synchronous active-high reset
//   CC_FETCH_nextPC_InBUS    in   next PC from the 2:1 mux output
//   CC_FETCH_redirect_In     in   mux selects branch target; flush + refetch
//   CC_FETCH_pcPlus4_OutBUS  out  PC + PC_INCREMENT (combinational from PC)
//   CC_FETCH_memAddr_OutBUS  out  instruction memory address (= PC)
//   CC_FETCH_memReq_Out      out  fetch request (registered)
//   CC_FETCH_memAck_In       in   memory ack, data valid same cycle
//   CC_FETCH_memData_InBUS   in   instruction word from memory
//   CC_FETCH_instr_OutBUS    out  buffered instruction
//   CC_FETCH_instrPC_OutBUS  out  address of the buffered instruction
//   CC_FETCH_valid_Out       out  buffered instruction valid
//   CC_FETCH_ready_In        in   decode accepts when valid & ready
// -----------------------------------------------------------------------------
module fetch_pc_sequencer #(
  parameter int unsigned                DATAWIDTH_BUS = 32,
  parameter logic [DATAWIDTH_BUS-1:0]   RESET_PC      = '0,
  parameter logic [DATAWIDTH_BUS-1:0]   PC_INCREMENT  = DATAWIDTH_BUS'(4)
) (
  input  logic                     CLOCK_50,
  input  logic                     RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] CC_FETCH_nextPC_InBUS,
  input  logic                     CC_FETCH_redirect_In,
  output logic [DATAWIDTH_BUS-1:0] CC_FETCH_pcPlus4_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] CC_FETCH_memAddr_OutBUS,
  output logic                     CC_FETCH_memReq_Out,
  input  logic                     CC_FETCH_memAck_In,
  input  logic [DATAWIDTH_BUS-1:0] CC_FETCH_memData_InBUS,
  output logic [DATAWIDTH_BUS-1:0] CC_FETCH_instr_OutBUS,
  output logic [DATAWIDTH_BUS-1:0] CC_FETCH_instrPC_OutBUS,
  output logic                     CC_FETCH_valid_Out,
  input  logic                     CC_FETCH_ready_In
);

  typedef enum logic [1:0] {
    StStart = 2'd0,
    StFetch = 2'd1,
    StHold  = 2'd2
  } state_e;

  state_e                   state_q,    state_d;
  logic [DATAWIDTH_BUS-1:0] pc_q,       pc_d;
  logic                     mem_req_q,  mem_req_d;
  logic                     valid_q,    valid_d;
  logic [DATAWIDTH_BUS-1:0] instr_q,    instr_d;
  logic [DATAWIDTH_BUS-1:0] instr_pc_q, instr_pc_d;

  // Next-state logic. Redirect outranks everything except reset: it loads
  // the mux output, kills any buffered instruction and discards a coincident
  // ack, so the refetch goes out on the very next cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_req_d  = mem_req_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    if (CC_FETCH_redirect_In) begin
      pc_d      = CC_FETCH_nextPC_InBUS;
      valid_d   = 1'b0;
      state_d   = StFetch;
      mem_req_d = 1'b1;
    end else begin
      unique case (state_q)
        StStart: begin
          state_d   = StFetch;
          mem_req_d = 1'b1;
        end
        StFetch: begin
          // Address stays on memAddr until ack; PC only moves on ack.
          if (CC_FETCH_memAck_In) begin
            instr_d    = CC_FETCH_memData_InBUS;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = CC_FETCH_nextPC_InBUS;
            state_d    = StHold;
            mem_req_d  = 1'b0;
          end
        end
        StHold: begin
          // valid is always set in this state, so ready alone means accept.
          if (CC_FETCH_ready_In) begin
            valid_d   = 1'b0;
            state_d   = StFetch;
            mem_req_d = 1'b1;
          end
        end
        default: begin
          state_d   = StStart;
          mem_req_d = 1'b0;
          valid_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET_InHigh) begin
      state_q    <= StStart;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_req_q  <= mem_req_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  // Modulo-2^DW add; wraps silently.
  assign CC_FETCH_pcPlus4_OutBUS = pc_q + PC_INCREMENT;
  assign CC_FETCH_memAddr_OutBUS = pc_q;
  assign CC_FETCH_memReq_Out     = mem_req_q;
  assign CC_FETCH_instr_OutBUS   = instr_q;
  assign CC_FETCH_instrPC_OutBUS = instr_pc_q;
  assign CC_FETCH_valid_Out      = valid_q;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Bench for fetch_pc_sequencer. Two instances share all control stimulus:
// index 0 resets to PC 0, index 1 resets to 0xFFFFFFFC to exercise wrap.
// Each has its own bench-side next-PC mux and memory image.
module tb_fetch_pc_sequencer;

  localparam int unsigned DW = 32;
  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFFC;
  localparam logic [31:0] INC  = 32'd4;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] target;
  logic        ack;
  logic        ready;

  logic [31:0] next_pc  [2];
  logic [31:0] pc_plus4 [2];
  logic [31:0] mem_addr [2];
  logic        mem_req  [2];
  logic [31:0] mem_data [2];
  logic [31:0] instr    [2];
  logic [31:0] instr_pc [2];
  logic        valid    [2];

  int vectors = 0;
  int errors  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_mux
    assign next_pc[g]  = redirect ? target : pc_plus4[g];
    assign mem_data[g] = mem_word(mem_addr[g]);
  end

  fetch_pc_sequencer #(.DATAWIDTH_BUS(DW), .RESET_PC(RPC0), .PC_INCREMENT(INC)) dut (
    .CLOCK_50                (clk),
    .RESET_InHigh            (rst),
    .CC_FETCH_nextPC_InBUS   (next_pc[0]),
    .CC_FETCH_redirect_In    (redirect),
    .CC_FETCH_pcPlus4_OutBUS (pc_plus4[0]),
    .CC_FETCH_memAddr_OutBUS (mem_addr[0]),
    .CC_FETCH_memReq_Out     (mem_req[0]),
    .CC_FETCH_memAck_In      (ack),
    .CC_FETCH_memData_InBUS  (mem_data[0]),
    .CC_FETCH_instr_OutBUS   (instr[0]),
    .CC_FETCH_instrPC_OutBUS (instr_pc[0]),
    .CC_FETCH_valid_Out      (valid[0]),
    .CC_FETCH_ready_In       (ready)
  );

  fetch_pc_sequencer #(.DATAWIDTH_BUS(DW), .RESET_PC(RPC1), .PC_INCREMENT(INC)) dut_wrap (
    .CLOCK_50                (clk),
    .RESET_InHigh            (rst),
    .CC_FETCH_nextPC_InBUS   (next_pc[1]),
    .CC_FETCH_redirect_In    (redirect),
    .CC_FETCH_pcPlus4_OutBUS (pc_plus4[1]),
    .CC_FETCH_memAddr_OutBUS (mem_addr[1]),
    .CC_FETCH_memReq_Out     (mem_req[1]),
    .CC_FETCH_memAck_In      (ack),
    .CC_FETCH_memData_InBUS  (mem_data[1]),
    .CC_FETCH_instr_OutBUS   (instr[1]),
    .CC_FETCH_instrPC_OutBUS (instr_pc[1]),
    .CC_FETCH_valid_Out      (valid[1]),
    .CC_FETCH_ready_In       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a PC, a one-slot buffer and a "just reset" warm-up flag.
  // A request is outstanding whenever the slot is empty and warm-up is done.
  // ---------------------------------------------------------------------------
  logic        model_ok = 1'b0;
  logic [31:0] m_pc   [2];
  logic        m_warm [2];
  logic        m_full [2];
  logic [31:0] m_instr[2];
  logic [31:0] m_ipc  [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [31:0] nxt;
      nxt = redirect ? target : m_pc[i] + INC;
      if (rst) begin
        m_pc[i]    = (i == 0) ? RPC0 : RPC1;
        m_warm[i]  = 1'b1;
        m_full[i]  = 1'b0;
        m_instr[i] = '0;
        m_ipc[i]   = '0;
      end else if (redirect) begin
        m_pc[i]   = nxt;
        m_full[i] = 1'b0;
        m_warm[i] = 1'b0;
      end else if (m_warm[i]) begin
        m_warm[i] = 1'b0;
      end else if (!m_full[i]) begin
        if (ack) begin
          m_instr[i] = mem_word(m_pc[i]);
          m_ipc[i]   = m_pc[i];
          m_full[i]  = 1'b1;
          m_pc[i]    = nxt;
        end
      end else if (ready) begin
        m_full[i] = 1'b0;
      end
    end
    if (rst) model_ok = 1'b1;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("memReq[%0d]", i), 32'(mem_req[i]), 32'(!m_warm[i] && !m_full[i]));
        check($sformatf("valid[%0d]", i), 32'(valid[i]), 32'(m_full[i]));
        check($sformatf("memAddr[%0d]", i), mem_addr[i], m_pc[i]);
        check($sformatf("pcPlus4[%0d]", i), pc_plus4[i], m_pc[i] + INC);
        if (m_full[i]) begin
          check($sformatf("instr[%0d]", i), instr[i], m_instr[i]);
          check($sformatf("instrPC[%0d]", i), instr_pc[i], m_ipc[i]);
        end
      end
    end
  end

  // One clock: inputs set before the call are sampled at this edge;
  // outputs are settled on return.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; target = '0; ack = 1'b0; ready = 1'b1;
    cyc(); cyc();
    check("rst memReq", 32'(mem_req[0]), 32'd0);
    check("rst valid", 32'(valid[0]), 32'd0);
    check("rst memAddr", mem_addr[0], 32'h0);
    check("rst pcPlus4", pc_plus4[0], 32'h4);
    check("rst wrap memAddr", mem_addr[1], 32'hFFFF_FFFC);
    check("rst wrap pcPlus4", pc_plus4[1], 32'h0);

    rst = 1'b0;
    check("start memReq", 32'(mem_req[0]), 32'd0);
    cyc();
    check("first req", 32'(mem_req[0]), 32'd1);
    check("first addr", mem_addr[0], 32'h0);

    // Sequential, zero-wait memory.
    ack = 1'b1;
    cyc();
    check("seq0 valid", 32'(valid[0]), 32'd1);
    check("seq0 instrPC", instr_pc[0], 32'h0);
    check("seq0 instr", instr[0], mem_word(32'h0));
    check("wrap0 instrPC", instr_pc[1], 32'hFFFF_FFFC);
    cyc();
    check("seq1 req", 32'(mem_req[0]), 32'd1);
    check("seq1 addr", mem_addr[0], 32'h4);
    check("wrap second addr", mem_addr[1], 32'h0);
    cyc();
    check("seq1 instrPC", instr_pc[0], 32'h4);
    ack = 1'b0;
    cyc();

    // Three wait states at 0x8.
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("wait req", 32'(mem_req[0]), 32'd1);
      check("wait addr", mem_addr[0], 32'h8);
      check("wait valid", 32'(valid[0]), 32'd0);
    end
    ack = 1'b1; ready = 1'b0;
    cyc();
    check("wait done instrPC", instr_pc[0], 32'h8);
    check("wait done pc", mem_addr[0], 32'hC);

    // Backpressure.
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("bp valid", 32'(valid[0]), 32'd1);
      check("bp instrPC", instr_pc[0], 32'h8);
      check("bp req", 32'(mem_req[0]), 32'd0);
    end
    ready = 1'b1;
    cyc();
    check("bp release valid", 32'(valid[0]), 32'd0);
    check("bp release addr", mem_addr[0], 32'hC);
    cyc();
    cyc();
    check("pre-redirect addr", mem_addr[0], 32'h10);

    // Redirect with coincident ack.
    redirect = 1'b1; target = 32'h100;
    cyc();
    check("redir valid", 32'(valid[0]), 32'd0);
    check("redir addr", mem_addr[0], 32'h100);
    check("redir req", 32'(mem_req[0]), 32'd1);
    redirect = 1'b0;
    cyc();
    check("redir instrPC", instr_pc[0], 32'h100);

    // Redirect in HOLD drops the buffer even with ready=1.
    redirect = 1'b1; target = 32'h200;
    cyc();
    check("hold redir valid", 32'(valid[0]), 32'd0);
    check("hold redir addr", mem_addr[0], 32'h200);
    redirect = 1'b0; ack = 1'b0;
    cyc();

    // Reset during a wait state.
    rst = 1'b1;
    cyc();
    check("midrst req", 32'(mem_req[0]), 32'd0);
    check("midrst addr", mem_addr[0], 32'h0);
    check("midrst wrap addr", mem_addr[1], 32'hFFFF_FFFC);
    rst = 1'b0;

    // Random traffic, checked every cycle by the model.
    for (int k = 0; k < 4000; k++) begin
      ack      = ($urandom_range(99) < 55);
      ready    = ($urandom_range(99) < 60);
      redirect = ($urandom_range(99) < 8);
      target   = {$urandom} & 32'hFFFF_FFFC;
      rst      = ($urandom_range(199) == 0);
      cyc();
    end
    rst = 1'b0; redirect = 1'b0;
    cyc();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
